// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with a start/done handshake.
// Multiplies either in one cycle or by shift-add; divides by restoring division on magnitudes.
module muldiv_unit #(
    parameter int XLEN     = 32,
    parameter bit FAST_MUL = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [CW-1:0]   CNT_INIT = CW'(XLEN);
    localparam logic [CW-1:0]   CNT_LAST = CW'(1);
    localparam logic [XLEN-1:0] MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ONES     = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [1:0]          op_lo_q;
    logic                a_neg_q, b_neg_q;
    logic                spec_q;
    logic [XLEN-1:0]     spec_res_q;
    logic [XLEN-1:0]     a_raw_q, b_raw_q;
    logic [CW-1:0]       cnt_q;
    logic [2*XLEN-1:0]   acc_q, mcand_q;
    logic [XLEN-1:0]     mplier_q;
    logic [XLEN-1:0]     quo_q, rem_q, div_q;
    logic                busy_q, done_q;
    logic [XLEN-1:0]     result_q;

    // Operand decode on the raw inputs, used only on the edge that accepts start.
    logic            a_signed_d, b_signed_d, a_neg_d, b_neg_d, spec_d;
    logic [XLEN-1:0] a_mag_d, b_mag_d, spec_res_d;

    always_comb begin
        a_signed_d = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
        b_signed_d = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
        a_neg_d    = a_signed_d & a[XLEN-1];
        b_neg_d    = b_signed_d & b[XLEN-1];
        a_mag_d    = a_neg_d ? (-a) : a;
        b_mag_d    = b_neg_d ? (-b) : b;
        spec_d     = (b == '0) || (a_signed_d && (a == MIN_VAL) && (b == ONES));
        if (b == '0) begin
            spec_res_d = op[1] ? a : ONES;
        end else begin
            spec_res_d = op[1] ? '0 : a;
        end
    end

    // One restoring-division step; the final step's values feed the sign fix directly.
    logic [XLEN:0]   rem_shift, rem_diff;
    logic            quo_bit;
    logic [XLEN-1:0] rem_nx, quo_nx, quo_fin, rem_fin, div_res;

    always_comb begin
        rem_shift = {rem_q, quo_q[XLEN-1]};
        rem_diff  = rem_shift - {1'b0, div_q};
        quo_bit   = ~rem_diff[XLEN];
        rem_nx    = quo_bit ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0];
        quo_nx    = {quo_q[XLEN-2:0], quo_bit};
        quo_fin   = (a_neg_q ^ b_neg_q) ? (-quo_nx) : quo_nx;
        rem_fin   = a_neg_q ? (-rem_nx) : rem_nx;
        div_res   = op_lo_q[1] ? rem_fin : quo_fin;
    end

    logic [2*XLEN-1:0] acc_nx, prod_iter, prod_fast, prod;
    logic [XLEN-1:0]   mul_res;

    always_comb begin
        acc_nx    = acc_q + (mplier_q[0] ? mcand_q : '0);
        prod_iter = (a_neg_q ^ b_neg_q) ? (-acc_nx) : acc_nx;
        // Sign-extended operands give the correct low 2*XLEN product bits for any signedness mix.
        prod_fast = {{XLEN{a_neg_q}}, a_raw_q} * {{XLEN{b_neg_q}}, b_raw_q};
        prod      = FAST_MUL ? prod_fast : prod_iter;
        mul_res   = (op_lo_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_lo_q    <= '0;
            a_neg_q    <= 1'b0;
            b_neg_q    <= 1'b0;
            spec_q     <= 1'b0;
            spec_res_q <= '0;
            a_raw_q    <= '0;
            b_raw_q    <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            div_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        op_lo_q    <= op[1:0];
                        a_neg_q    <= a_neg_d;
                        b_neg_q    <= b_neg_d;
                        a_raw_q    <= a;
                        b_raw_q    <= b;
                        spec_q     <= spec_d;
                        spec_res_q <= spec_res_d;
                        cnt_q      <= CNT_INIT;
                        acc_q      <= '0;
                        mcand_q    <= {{XLEN{1'b0}}, a_mag_d};
                        mplier_q   <= b_mag_d;
                        quo_q      <= a_mag_d;
                        rem_q      <= '0;
                        div_q      <= b_mag_d;
                        busy_q     <= 1'b1;
                        state_q    <= op[2] ? S_DIV : S_MUL;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_MUL: begin
                    if (FAST_MUL || (cnt_q == CNT_LAST)) begin
                        result_q <= mul_res;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= S_DONE;
                    end else begin
                        acc_q    <= acc_nx;
                        mcand_q  <= {mcand_q[2*XLEN-2:0], 1'b0};
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q - CNT_LAST;
                    end
                end
                S_DIV: begin
                    if (spec_q || (cnt_q == CNT_LAST)) begin
                        result_q <= spec_q ? spec_res_q : div_res;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= S_DONE;
                    end else begin
                        quo_q <= quo_nx;
                        rem_q <= rem_nx;
                        cnt_q <= cnt_q - CNT_LAST;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: three instances (32-bit fast mul, 32-bit iterative, 16-bit iterative)
// share stimulus; results, latency, busy length and done pulses are checked against a reference model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [2:0]  busy_w, done_w;
    logic [31:0] res0, res1;
    logic [15:0] res2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32), .FAST_MUL(1'b1)) u_fast32 (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy_w[0]), .done(done_w[0]), .result(res0)
    );
    muldiv_unit #(.XLEN(32), .FAST_MUL(1'b0)) u_iter32 (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy_w[1]), .done(done_w[1]), .result(res1)
    );
    muldiv_unit #(.XLEN(16), .FAST_MUL(1'b0)) u_iter16 (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a[15:0]), .b(b[15:0]),
        .busy(busy_w[2]), .done(done_w[2]), .result(res2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic int dut_w(input int d);
        return (d == 2) ? 16 : 32;
    endfunction

    function automatic logic [31:0] dut_res(input int d);
        case (d)
            0:       return res0;
            1:       return res1;
            default: return {16'h0, res2};
        endcase
    endfunction

    function automatic logic [31:0] wmask(input int w);
        return (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    // Reference: RV32M semantics with wide signed integer arithmetic.
    function automatic logic [31:0] ref_model(input int w, input logic [2:0] f3,
                                              input logic [31:0] x, input logic [31:0] y);
        logic signed [127:0] one, mask, ua, ub, sa, sb, minv, res;
        one  = 128'sd1;
        mask = (one <<< w) - one;
        ua   = $signed({96'd0, x}) & mask;
        ub   = $signed({96'd0, y}) & mask;
        sa   = ua[w-1] ? ua - (one <<< w) : ua;
        sb   = ub[w-1] ? ub - (one <<< w) : ub;
        minv = -(one <<< (w - 1));
        case (f3)
            3'd0: res = ua * ub;
            3'd1: res = (sa * sb) >>> w;
            3'd2: res = (sa * ub) >>> w;
            3'd3: res = (ua * ub) >>> w;
            3'd4: res = (ub == 0) ? mask : ((sa == minv && sb == -1) ? sa : sa / sb);
            3'd5: res = (ub == 0) ? mask : ua / ub;
            3'd6: res = (ub == 0) ? ua : ((sa == minv && sb == -1) ? 128'sd0 : sa % sb);
            default: res = (ub == 0) ? ua : ua % ub;
        endcase
        return res[31:0] & mask[31:0];
    endfunction

    function automatic int exp_lat(input int d, input logic [2:0] f3,
                                   input logic [31:0] x, input logic [31:0] y);
        int w;
        logic [31:0] m, xm, ym, minm;
        w    = dut_w(d);
        m    = wmask(w);
        xm   = x & m;
        ym   = y & m;
        minm = (m >> 1) + 32'd1;
        if (!f3[2]) return (d == 0) ? 2 : w + 1;
        if (ym == 0) return 2;
        if ((f3 == 3'd4 || f3 == 3'd6) && xm == minm && ym == m) return 2;
        return w + 1;
    endfunction

    // Issues one op at the current negedge and follows all three units until each has finished.
    task automatic run_txn(input logic [2:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b,
                           input int glitch_cyc, input bit has_exp, input logic [31:0] exp32,
                           input string tag);
        int lat [3];
        int bcnt [3];
        int dcnt [3];
        logic [31:0] cap [3];
        bit all_done;
        for (int d = 0; d < 3; d++) begin
            lat[d] = -1; bcnt[d] = 0; dcnt[d] = 0; cap[d] = 'x;
        end
        op = t_op; a = t_a; b = t_b; start = 1'b1;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                start = 1'b0; a = $urandom; b = $urandom;
            end
            if (glitch_cyc > 0 && cyc == glitch_cyc) begin
                start = 1'b1; op = t_op ^ 3'b001; a = $urandom; b = $urandom;
            end
            if (glitch_cyc > 0 && cyc == glitch_cyc + 1) start = 1'b0;
            all_done = 1'b1;
            for (int d = 0; d < 3; d++) begin
                if (busy_w[d]) bcnt[d]++;
                if (done_w[d]) begin
                    dcnt[d]++;
                    if (lat[d] < 0) begin
                        lat[d] = cyc; cap[d] = dut_res(d);
                    end
                end
                if (lat[d] < 0) all_done = 1'b0;
            end
            if (all_done && !start) break;
        end
        for (int d = 0; d < 3; d++) begin
            int el;
            el = exp_lat(d, t_op, t_a, t_b);
            chk($sformatf("%s.res%0d", tag, d), cap[d], ref_model(dut_w(d), t_op, t_a, t_b));
            chk($sformatf("%s.lat%0d", tag, d), lat[d], el);
            chk($sformatf("%s.busy%0d", tag, d), bcnt[d], el - 1);
            chk($sformatf("%s.pulses%0d", tag, d), dcnt[d], 1);
            if (has_exp && d < 2) chk($sformatf("%s.const%0d", tag, d), cap[d], exp32);
        end
        $display("txn %s op=%0d a=%h b=%h res=%h/%h/%h lat=%0d/%0d/%0d", tag, t_op, t_a, t_b,
                 cap[0], cap[1], cap[2], lat[0], lat[1], lat[2]);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t dir_v [10];
    logic [31:0] pick_v [6];

    function automatic logic [31:0] pick_operand();
        if ($urandom_range(0, 1) == 0) return pick_v[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin
        int dpulse;
        dir_v[0] = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
        dir_v[1] = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
        dir_v[2] = '{3'd5, 32'h0000_1234, 32'd0,         32'hFFFF_FFFF};
        dir_v[3] = '{3'd7, 32'h0000_1234, 32'd0,         32'h0000_1234};
        dir_v[4] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        dir_v[5] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        dir_v[6] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        dir_v[7] = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        dir_v[8] = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        dir_v[9] = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
        pick_v[0] = 32'h0; pick_v[1] = 32'hFFFF_FFFF; pick_v[2] = 32'h8000_0000;
        pick_v[3] = 32'h1; pick_v[4] = 32'hFFFF_8000; pick_v[5] = 32'h0000_FFFF;

        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset.busy%0d", d), busy_w[d], 1'b0);
            chk($sformatf("reset.done%0d", d), done_w[d], 1'b0);
            chk($sformatf("reset.res%0d", d), dut_res(d), 32'h0);
        end

        for (int i = 0; i < 10; i++)
            run_txn(dir_v[i].op, dir_v[i].a, dir_v[i].b, 0, 1'b1, dir_v[i].exp, $sformatf("dir%0d", i));

        run_txn(3'd4, 32'hFFFF_FFF9, 32'd2, 5, 1'b1, 32'hFFFF_FFFD, "glitch");
        // Special-case divide finishes everywhere in cycle 2, so the next op starts in the DONE cycle.
        run_txn(3'd5, 32'h0000_1234, 32'd0, 0, 1'b1, 32'hFFFF_FFFF, "b2b_a");
        run_txn(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b1, 32'hFFFF_FFFE, "b2b_b");

        op = 3'd4; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("abort.busy%0d", d), busy_w[d], 1'b0);
            chk($sformatf("abort.done%0d", d), done_w[d], 1'b0);
            chk($sformatf("abort.res%0d", d), dut_res(d), 32'h0);
        end
        dpulse = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_w != 3'b000) dpulse++;
        end
        chk("abort.no_done", dpulse, 0);
        $display("txn abort op=4 a=000003e8 b=00000003 late_done_cycles=%0d", dpulse);

        for (int i = 0; i < 1200; i++) begin
            logic [2:0] r_op;
            r_op = 3'($urandom_range(0, 7));
            run_txn(r_op, pick_operand(), pick_operand(), 0, 1'b0, 32'h0, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
